// File: rtl/cfg_mux_bank_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cfg_mux_bank_if : serial configuration / status bundle for cfg_mux_bank      |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
interface cfg_mux_bank_if #(
   parameter int N_IN = 16,
   parameter int N_CH = 4
);
   localparam int SEL_W      = $clog2(N_IN);
   localparam int FRAME_BITS = N_CH * SEL_W;

   logic                  cfg_valid;
   logic                  cfg_data;
   logic                  cfg_ready;
   logic                  commit;
   logic                  abort;
   logic                  frame_done;
   logic                  cfg_err;
   logic [FRAME_BITS-1:0] sel_active;

   modport master (
      output cfg_valid, cfg_data, commit, abort,
      input  cfg_ready, frame_done, cfg_err, sel_active
   );

   modport slave (
      input  cfg_valid, cfg_data, commit, abort,
      output cfg_ready, frame_done, cfg_err, sel_active
   );
endinterface
`default_nettype wire

// File: rtl/cfg_mux_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cfg_mux_bank : N_CH routing muxes with serially loaded, atomically          |
// |                committed select frame                                       |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module cfg_mux_bank #(
   parameter int N_IN = 16,
   parameter int N_CH = 4
) (
   input  wire logic                 CLK,
   input  wire logic                 RST,
   cfg_mux_bank_if.slave             bus,
   input  wire logic [N_CH*N_IN-1:0] IN,
   output logic      [N_CH-1:0]      O
);
   localparam int SEL_W      = $clog2(N_IN);
   localparam int FRAME_BITS = N_CH * SEL_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t                state_q,   state_d;
   logic [FRAME_BITS-1:0] shadow_q,  shadow_d;
   logic [FRAME_BITS-1:0] active_q,  active_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  cfg_err_q, cfg_err_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_LOAD;
         shadow_q  <= '0;
         active_q  <= '0;
         bit_cnt_q <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         bit_cnt_q <= bit_cnt_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Event priority below RST: abort, then commit, then shifting a bit in.
   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      bit_cnt_d = bit_cnt_q;
      cfg_err_d = cfg_err_q;

      if (bus.abort) begin
         bit_cnt_d = '0;
         state_d   = ST_LOAD;
      end else if (bus.commit) begin
         if (state_q == ST_FULL) begin
            active_d = shadow_q;
            state_d  = ST_LOAD;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else if (state_q == ST_LOAD && bus.cfg_valid) begin
         shadow_d = {shadow_q[FRAME_BITS-2:0], bus.cfg_data};
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_FULL;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
   end

   assign bus.cfg_ready  = (state_q == ST_LOAD);
   assign bus.frame_done = (state_q == ST_FULL);
   assign bus.cfg_err    = cfg_err_q;
   assign bus.sel_active = active_q;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [N_IN-1:0]  ch_in;
      logic [SEL_W-1:0] ch_sel;
      assign ch_in  = IN[c*N_IN +: N_IN];
      assign ch_sel = active_q[c*SEL_W +: SEL_W];
      assign O[c]   = ch_in[ch_sel];
   end
endmodule
`default_nettype wire
